// File: rtl/rdc_offender_log.sv
// Offender logger for the RDC interruption vector: rising bits are serialised into
// a FIFO of {core, event, timestamp} records that software drains through a valid/ready port.
module rdc_offender_log #(
    parameter int N_CORES     = 4,
    parameter int CORE_EVENTS = 2,
    parameter int TS_WIDTH    = 32,
    parameter int DEPTH       = 8,
    localparam int N_SIG      = N_CORES * CORE_EVENTS,
    localparam int CID_W      = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int EID_W      = (CORE_EVENTS > 1) ? $clog2(CORE_EVENTS) : 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic [CORE_EVENTS-1:0] irq_vector_i [0:N_CORES-1],
    output logic                   rec_valid_o,
    input  logic                   rec_ready_i,
    output logic [CID_W-1:0]       rec_core_o,
    output logic [EID_W-1:0]       rec_event_o,
    output logic [TS_WIDTH-1:0]    rec_time_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   overflow_o,
    output logic                   irq_o
);

    typedef struct packed {
        logic [CID_W-1:0]    core;
        logic [EID_W-1:0]    evt;
        logic [TS_WIDTH-1:0] ts;
    } rec_t;

    function automatic logic [TS_WIDTH-1:0] sat_inc(input logic [TS_WIDTH-1:0] v);
        return (&v) ? v : v + TS_WIDTH'(1);
    endfunction

    logic [N_SIG-1:0]    vec_flat;
    logic [N_SIG-1:0]    vec_q;
    logic [N_SIG-1:0]    pending_q;
    logic [N_SIG-1:0]    pending_d;
    logic [N_SIG-1:0]    rise;
    logic [N_SIG-1:0]    cand;
    logic [N_SIG-1:0]    served_oh;
    logic [CID_W-1:0]    served_core;
    logic [EID_W-1:0]    served_evt;
    logic [TS_WIDTH-1:0] ts_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                ovf_q;
    logic                irq_q;
    logic                full;
    logic                pop;
    logic                push;
    rec_t                mem [DEPTH];
    rec_t                head;

    always_comb begin
        vec_flat = '0;
        for (int c = 0; c < N_CORES; c++) begin
            for (int e = 0; e < CORE_EVENTS; e++) begin
                vec_flat[c*CORE_EVENTS + e] = irq_vector_i[c][e];
            end
        end
    end

    assign rise      = vec_flat & ~vec_q & {N_SIG{enable_i}};
    assign cand      = pending_q | rise;
    assign served_oh = cand & (~cand + N_SIG'(1));

    // Descending scan so the lowest set index is the one left assigned.
    always_comb begin
        served_core = '0;
        served_evt  = '0;
        for (int c = N_CORES - 1; c >= 0; c--) begin
            for (int e = CORE_EVENTS - 1; e >= 0; e--) begin
                if (cand[c*CORE_EVENTS + e]) begin
                    served_core = CID_W'(c);
                    served_evt  = EID_W'(e);
                end
            end
        end
    end

    assign rec_valid_o = (count_q != '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign pop         = rec_valid_o && rec_ready_i;
    assign push        = enable_i && (cand != '0) && (!full || pop);
    assign pending_d   = enable_i ? (cand & ~(push ? served_oh : '0)) : '0;
    assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);

    // Record storage: data only, never reset
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{core: served_core, evt: served_evt, ts: ts_q};
        end
    end

    // Control state
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            vec_q     <= '0;
            pending_q <= '0;
            ts_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            vec_q <= enable_i ? vec_flat : '0;
            if (clear_i) begin
                pending_q <= '0;
                ts_q      <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                count_q   <= '0;
                ovf_q     <= 1'b0;
                irq_q     <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q   <= count_d;
                pending_q <= pending_d;
                if (enable_i) ts_q <= sat_inc(ts_q);
                // A re-raise of a still-unlogged offender means one violation is lost.
                if ((rise & pending_q) != '0) ovf_q <= 1'b1;
                irq_q <= (count_d != '0);
            end
        end
    end

    assign head        = mem[rd_ptr_q];
    assign rec_core_o  = rec_valid_o ? head.core : '0;
    assign rec_event_o = rec_valid_o ? head.evt  : '0;
    assign rec_time_o  = rec_valid_o ? head.ts   : '0;
    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_rdc_offender_log.sv
// Bench for rdc_offender_log: hand-computed vector table, directed full/overflow/saturation
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_rdc_offender_log;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults: 4 cores x 2 events, 32-bit ts, depth 8)
    logic        m_rstn, m_en, m_clr, m_rdy;
    logic [7:0]  m_vec;
    logic [1:0]  m_iv [0:3];
    logic        m_valid, m_ovf, m_irq;
    logic [1:0]  m_core;
    logic        m_evt;
    logic [31:0] m_time;
    logic [3:0]  m_cnt;

    // Small instance with 4-bit timestamp
    logic        s_rstn, s_en, s_clr, s_rdy;
    logic [7:0]  s_vec;
    logic [1:0]  s_iv [0:3];
    logic        s_valid, s_ovf, s_irq;
    logic [1:0]  s_core;
    logic        s_evt;
    logic [3:0]  s_time;
    logic [3:0]  s_cnt;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            m_iv[c] = m_vec[c*2 +: 2];
            s_iv[c] = s_vec[c*2 +: 2];
        end
    end

    rdc_offender_log dut (
        .clk_i(clk), .rstn_i(m_rstn), .enable_i(m_en), .clear_i(m_clr),
        .irq_vector_i(m_iv), .rec_valid_o(m_valid), .rec_ready_i(m_rdy),
        .rec_core_o(m_core), .rec_event_o(m_evt), .rec_time_o(m_time),
        .count_o(m_cnt), .overflow_o(m_ovf), .irq_o(m_irq)
    );

    rdc_offender_log #(.TS_WIDTH(4)) dut_small (
        .clk_i(clk), .rstn_i(s_rstn), .enable_i(s_en), .clear_i(s_clr),
        .irq_vector_i(s_iv), .rec_valid_o(s_valid), .rec_ready_i(s_rdy),
        .rec_core_o(s_core), .rec_event_o(s_evt), .rec_time_o(s_time),
        .count_o(s_cnt), .overflow_o(s_ovf), .irq_o(s_irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: records as a queue, offenders as bit sets
    typedef struct {
        int          core;
        int          ev;
        logic [31:0] t;
    } rec_t;
    rec_t        q[$];
    logic [7:0]  md_pend, md_vq;
    logic [31:0] md_ts;
    bit          md_ovf, md_irq;

    task automatic model_reset_state();
        q.delete();
        md_pend = '0;
        md_ts   = '0;
        md_ovf  = 0;
        md_irq  = 0;
    endtask

    task automatic model_update(input bit rn, en, cl, rd, input logic [7:0] v);
        logic [7:0] rise, cand;
        bit pop, push;
        int s;
        rec_t r;
        pop = (q.size() != 0) && rd;
        if (!rn) begin
            model_reset_state();
            md_vq = '0;
            return;
        end
        rise  = en ? (v & ~md_vq) : 8'h00;
        md_vq = en ? v : 8'h00;
        if (cl) begin
            model_reset_state();
            return;
        end
        if ((rise & md_pend) != 0) md_ovf = 1;
        cand = md_pend | rise;
        push = en && (cand != 0) && (q.size() < 8 || pop);
        if (pop) void'(q.pop_front());
        if (push) begin
            s = 0;
            while (!cand[s]) s++;
            r.core = s / 2;
            r.ev   = s % 2;
            r.t    = md_ts;
            q.push_back(r);
            cand[s] = 1'b0;
        end
        md_pend = en ? cand : 8'h00;
        if (en && md_ts != 32'hFFFF_FFFF) md_ts++;
        md_irq = (q.size() != 0);
    endtask

    task automatic compare_model();
        chk("model.valid", m_valid, q.size() != 0);
        chk("model.count", m_cnt, q.size());
        chk("model.ovf", m_ovf, md_ovf);
        chk("model.irq", m_irq, md_irq);
        if (q.size() != 0) begin
            chk("model.core", m_core, q[0].core);
            chk("model.event", m_evt, q[0].ev);
            chk("model.time", m_time, q[0].t);
        end else begin
            chk("model.core_idle", m_core, 0);
            chk("model.time_idle", m_time, 0);
        end
    endtask

    task automatic step(input bit rn, en, cl, rd, input logic [7:0] v);
        m_rstn = rn; m_en = en; m_clr = cl; m_rdy = rd; m_vec = v;
        @(posedge clk);
        model_update(rn, en, cl, rd, v);
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          rn, en, cl, rd;
        logic [7:0]  v;
        bit          e_valid;
        int          e_core, e_ev;
        logic [31:0] e_time;
        int          e_cnt;
        bit          e_ovf, e_irq;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit rn, en, cl, rd, input logic [7:0] v, input bit ev,
                       input int ec, ee, input logic [31:0] et, input int ecnt,
                       input bit eo, ei);
        vec_t t;
        t.rn = rn; t.en = en; t.cl = cl; t.rd = rd; t.v = v;
        t.e_valid = ev; t.e_core = ec; t.e_ev = ee; t.e_time = et;
        t.e_cnt = ecnt; t.e_ovf = eo; t.e_irq = ei;
        tbl.push_back(t);
    endtask

    initial begin
        logic [7:0] rv, mask;
        m_rstn = 0; m_en = 0; m_clr = 0; m_rdy = 0; m_vec = '0;
        s_rstn = 0; s_en = 0; s_clr = 0; s_rdy = 0; s_vec = '0;
        md_vq = '0;
        model_reset_state();

        // Reset, one offender at ts=5, then three simultaneous offenders at ts=10
        add(0,0,0,0,8'h00, 0,0,0,0, 0,0,0);
        for (int i = 0; i < 5; i++) add(1,1,0,0,8'h00, 0,0,0,0, 0,0,0);
        add(1,1,0,0,8'h20, 1,2,1,5,  1,0,1);
        add(1,1,0,1,8'h20, 0,0,0,0,  0,0,0);
        for (int i = 0; i < 3; i++) add(1,1,0,0,8'h00, 0,0,0,0, 0,0,0);
        add(1,1,0,0,8'h49, 1,0,0,10, 1,0,1);
        add(1,1,0,0,8'h49, 1,0,0,10, 2,0,1);
        add(1,1,0,0,8'h49, 1,0,0,10, 3,0,1);
        add(1,1,0,1,8'h49, 1,1,1,11, 2,0,1);
        add(1,1,0,1,8'h49, 1,3,0,12, 1,0,1);
        add(1,1,0,1,8'h49, 0,0,0,0,  0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rn, tbl[i].en, tbl[i].cl, tbl[i].rd, tbl[i].v);
            chk($sformatf("tbl%0d.valid", i), m_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d.core", i),  m_core,  tbl[i].e_core);
            chk($sformatf("tbl%0d.event", i), m_evt,   tbl[i].e_ev);
            chk($sformatf("tbl%0d.time", i),  m_time,  tbl[i].e_time);
            chk($sformatf("tbl%0d.count", i), m_cnt,   tbl[i].e_cnt);
            chk($sformatf("tbl%0d.ovf", i),   m_ovf,   tbl[i].e_ovf);
            chk($sformatf("tbl%0d.irq", i),   m_irq,   tbl[i].e_irq);
        end

        // Fill to DEPTH with a ninth offender held pending, then push+pop at full
        step(1,1,0,0,8'h00);
        for (int i = 0; i < 8; i++) step(1,1,0,0,8'hFF);
        chk("full.count", m_cnt, 8);
        chk("full.head_core", m_core, 0);
        step(1,1,0,0,8'hFE);
        step(1,1,0,0,8'hFF);
        chk("ninth.count", m_cnt, 8);
        chk("ninth.ovf", m_ovf, 0);
        step(1,1,0,1,8'hFF);
        chk("pushpop.count", m_cnt, 8);
        chk("pushpop.head_event", m_evt, 1);
        chk("pushpop.ovf", m_ovf, 0);
        for (int i = 0; i < 7; i++) step(1,1,0,1,8'hFF);
        chk("tail.count", m_cnt, 1);
        chk("tail.core", m_core, 0);
        chk("tail.event", m_evt, 0);

        // Re-raise of a pending offender in a full FIFO -> sticky overflow until clear
        step(1,1,0,0,8'h00);
        for (int i = 0; i < 7; i++) step(1,1,0,0,8'hFF);
        chk("ovf.full", m_cnt, 8);
        step(1,1,0,0,8'h7F);
        chk("ovf.before", m_ovf, 0);
        step(1,1,0,0,8'hFF);
        chk("ovf.set", m_ovf, 1);
        step(1,1,0,1,8'hFF);
        step(1,0,0,1,8'hFF);
        chk("ovf.sticky", m_ovf, 1);
        step(1,1,1,0,8'hFF);
        chk("clear.count", m_cnt, 0);
        chk("clear.ovf", m_ovf, 0);
        chk("clear.valid", m_valid, 0);
        chk("clear.irq", m_irq, 0);

        // Timestamp saturation and clear on the 4-bit instance
        s_rstn = 1; s_en = 1;
        for (int i = 0; i < 20; i++) step(1,1,0,1,8'h00);
        s_vec = 8'h01;
        step(1,1,0,1,8'h00);
        chk("sat.count", s_cnt, 1);
        chk("sat.time", s_time, 4'hF);
        chk("sat.irq", s_irq, 1);
        s_clr = 1;
        step(1,1,0,1,8'h00);
        chk("sclr.count", s_cnt, 0);
        chk("sclr.valid", s_valid, 0);
        chk("sclr.ovf", s_ovf, 0);
        chk("sclr.irq", s_irq, 0);
        s_clr = 0; s_vec = 8'h03;
        step(1,1,0,1,8'h00);
        chk("sclr.time_restart", s_time, 0);
        chk("sclr.core", s_core, 0);
        chk("sclr.event", s_evt, 1);

        // Randomized traffic against the reference model
        rv = '0;
        for (int i = 0; i < 3000; i++) begin
            mask = '0;
            for (int b = 0; b < 8; b++) mask[b] = ($urandom_range(0, 7) == 0);
            rv = rv ^ mask;
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 15) != 0,
                 $urandom_range(0, 149) == 0,
                 (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
